// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: bundles the stall/flush controller's request inputs and control outputs.
//   master : pipeline side - drives stall requests and the exception report, receives
//            stall/flush/new_pc and the performance counters.
//   slave  : pipe_ctrl side.
// Signals: stallreq_{if,id,ex,mem}, exc_valid_i, exc_is_eret_i, cp0_epc_i[31:0] (requests);
//          stall[5:0], flush, new_pc[31:0], stall_cycles[CNT_W-1:0], flush_count[15:0].
interface pipe_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             stallreq_if;
  logic             stallreq_id;
  logic             stallreq_ex;
  logic             stallreq_mem;
  logic             exc_valid_i;
  logic             exc_is_eret_i;
  logic [31:0]      cp0_epc_i;
  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      new_pc;
  logic [CNT_W-1:0] stall_cycles;
  logic [15:0]      flush_count;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output exc_valid_i, exc_is_eret_i, cp0_epc_i,
    input  stall, flush, new_pc, stall_cycles, flush_count
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  exc_valid_i, exc_is_eret_i, cp0_epc_i,
    output stall, flush, new_pc, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush controller for the 5-stage MIPS pipeline.
// Merges per-stage stall requests into stall[5:0] ([0]=PC .. [5]=WB), issues exception/ERET
// flushes (deferred while an instruction or data SRAM access is in flight) and keeps
// stall-cycle / flush performance counters.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - pipe_ctrl_if.slave: stall requests, exception report, stall/flush/new_pc, counters
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int unsigned CNT_W      = 32
) (
  input logic         clk,
  input logic         rst,
  pipe_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_PEND  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [5:0] STALL_MEM = 6'b011111;
  localparam logic [5:0] STALL_EX  = 6'b001111;
  localparam logic [5:0] STALL_ID  = 6'b000111;
  localparam logic [5:0] STALL_IF  = 6'b000011;

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [31:0]      r_pend_pc;
  logic [31:0]      w_pend_pc_next;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [15:0]      r_flush_count;

  logic             w_bus_busy;
  logic [31:0]      w_exc_target;
  logic [5:0]       w_stall_merge;
  logic [5:0]       w_stall;
  logic             w_flush;
  logic [31:0]      w_new_pc;

  // A flush cannot be issued while either SRAM bus has a transaction outstanding.
  assign w_bus_busy   = bus.stallreq_if | bus.stallreq_mem;
  assign w_exc_target = bus.exc_is_eret_i ? bus.cp0_epc_i : EXC_VECTOR;

  // Deepest requesting stage wins: it holds itself and everything upstream.
  always_comb begin
    w_stall_merge = '0;
    if (bus.stallreq_mem) begin
      w_stall_merge = STALL_MEM;
    end else if (bus.stallreq_ex) begin
      w_stall_merge = STALL_EX;
    end else if (bus.stallreq_id) begin
      w_stall_merge = STALL_ID;
    end else if (bus.stallreq_if) begin
      w_stall_merge = STALL_IF;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_pend_pc_next = r_pend_pc;
    w_stall        = '0;
    w_flush        = 1'b0;
    w_new_pc       = '0;
    case (r_state)
      ST_RUN: begin
        if (bus.exc_valid_i && !w_bus_busy) begin
          w_flush  = 1'b1;
          w_new_pc = w_exc_target;
        end else if (bus.exc_valid_i) begin
          // Hold the excepting instruction in MEM until the bus drains.
          w_stall        = STALL_MEM;
          w_pend_pc_next = w_exc_target;
          w_state_next   = ST_PEND;
        end else begin
          w_stall = w_stall_merge;
        end
      end
      ST_PEND: begin
        w_stall = STALL_MEM;
        if (!w_bus_busy) begin
          w_state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        w_flush      = 1'b1;
        w_new_pc     = r_pend_pc;
        w_state_next = ST_RUN;
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
    // Keep the pipeline quiet while reset is held.
    if (rst) begin
      w_stall  = '0;
      w_flush  = 1'b0;
      w_new_pc = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_RUN;
      r_pend_pc      <= '0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pend_pc <= w_pend_pc_next;
      if (w_stall != 6'b000000) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (w_flush && (r_flush_count != 16'hFFFF)) begin
        r_flush_count <= r_flush_count + 16'd1;
      end
    end
  end

  assign bus.stall        = w_stall;
  assign bus.flush        = w_flush;
  assign bus.new_pc       = w_new_pc;
  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_count  = r_flush_count;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: self-checking bench for pipe_ctrl - fixed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural reference model.
module tb_pipe_ctrl;

  localparam logic [31:0] VEC = 32'hBFC00380;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(32)) bus ();

  pipe_ctrl #(
    .EXC_VECTOR(VEC),
    .CNT_W     (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic        f, d, e, m, x, r;
    logic [31:0] epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
  } vec_t;

  // Reference model state: an exception waiting for the bus, and a flush due next cycle.
  bit          m_pending;
  bit          m_flush_due;
  logic [31:0] m_target;
  logic [31:0] m_stall_cycles;
  logic [15:0] m_flush_count;
  logic [5:0]  e_stall;
  logic        e_flush;
  logic [31:0] e_pc;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else n_pass++;
  endtask

  task automatic set_in(input logic f, d, e, m, x, r, input logic [31:0] epc);
    bus.stallreq_if   = f;
    bus.stallreq_id   = d;
    bus.stallreq_ex   = e;
    bus.stallreq_mem  = m;
    bus.exc_valid_i   = x;
    bus.exc_is_eret_i = r;
    bus.cp0_epc_i     = epc;
  endtask

  task automatic chk_out(input string name, input logic [5:0] s, input logic fl,
                         input logic [31:0] pc);
    chk({name, ".stall"}, {26'd0, bus.stall}, {26'd0, s});
    chk({name, ".flush"}, {31'd0, bus.flush}, {31'd0, fl});
    chk({name, ".new_pc"}, bus.new_pc, pc);
  endtask

  // Drive at negedge, compare combinational outputs 2 time units later, then take the edge.
  task automatic step(input string name, input logic f, d, e, m, x, r, input logic [31:0] epc,
                      input logic [5:0] s, input logic fl, input logic [31:0] pc);
    @(negedge clk);
    set_in(f, d, e, m, x, r, epc);
    #2 chk_out(name, s, fl, pc);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Stage index of the deepest requester (IF=1..MEM=4) selects a mask of that many+1 low bits.
  function automatic logic [5:0] merge(input logic f, d, e, m);
    int top = 0;
    if (f) top = 1;
    if (d) top = 2;
    if (e) top = 3;
    if (m) top = 4;
    return (top == 0) ? 6'd0 : 6'((2 << top) - 1);
  endfunction

  task automatic model_eval();
    logic busy = bus.stallreq_if | bus.stallreq_mem;
    e_stall = 6'd0;
    e_flush = 1'b0;
    e_pc    = 32'd0;
    if (rst) begin
    end else if (m_flush_due) begin
      e_flush = 1'b1;
      e_pc    = m_target;
    end else if (m_pending) begin
      e_stall = 6'h1f;
    end else if (bus.exc_valid_i) begin
      if (busy) e_stall = 6'h1f;
      else begin
        e_flush = 1'b1;
        e_pc    = bus.exc_is_eret_i ? bus.cp0_epc_i : VEC;
      end
    end else begin
      e_stall = merge(bus.stallreq_if, bus.stallreq_id, bus.stallreq_ex, bus.stallreq_mem);
    end
  endtask

  task automatic model_clock();
    logic busy = bus.stallreq_if | bus.stallreq_mem;
    if (rst) begin
      m_pending      = 0;
      m_flush_due    = 0;
      m_target       = 32'd0;
      m_stall_cycles = 32'd0;
      m_flush_count  = 16'd0;
    end else begin
      if (e_stall != 0) m_stall_cycles = m_stall_cycles + 1;
      if (e_flush && m_flush_count != 16'hFFFF) m_flush_count = m_flush_count + 1;
      if (m_flush_due) m_flush_due = 0;
      else if (m_pending) begin
        if (!busy) begin
          m_pending   = 0;
          m_flush_due = 1;
        end
      end else if (bus.exc_valid_i && busy) begin
        m_pending = 1;
        m_target  = bus.exc_is_eret_i ? bus.cp0_epc_i : VEC;
      end
    end
  endtask

  vec_t vecs[15];

  initial begin
    int exp_sc;
    int exp_fc;
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 32'h0,        6'b000000, 0, 32'h0};
    vecs[1]  = '{1, 0, 0, 0, 0, 0, 32'h0,        6'b000011, 0, 32'h0};
    vecs[2]  = '{0, 1, 0, 0, 0, 0, 32'h0,        6'b000111, 0, 32'h0};
    vecs[3]  = '{0, 0, 1, 0, 0, 0, 32'h0,        6'b001111, 0, 32'h0};
    vecs[4]  = '{0, 0, 0, 1, 0, 0, 32'h0,        6'b011111, 0, 32'h0};
    vecs[5]  = '{1, 1, 0, 0, 0, 0, 32'h0,        6'b000111, 0, 32'h0};
    vecs[6]  = '{0, 1, 0, 1, 0, 0, 32'h0,        6'b011111, 0, 32'h0};
    vecs[7]  = '{1, 1, 1, 1, 0, 0, 32'h0,        6'b011111, 0, 32'h0};
    vecs[8]  = '{0, 0, 1, 1, 0, 0, 32'h0,        6'b011111, 0, 32'h0};
    vecs[9]  = '{1, 0, 1, 0, 0, 0, 32'h0,        6'b001111, 0, 32'h0};
    vecs[10] = '{0, 0, 0, 0, 1, 0, 32'h0,        6'b000000, 1, 32'hBFC00380};
    vecs[11] = '{0, 1, 1, 0, 1, 0, 32'h0,        6'b000000, 1, 32'hBFC00380};
    vecs[12] = '{0, 0, 0, 0, 1, 1, 32'h12345678, 6'b000000, 1, 32'h12345678};
    vecs[13] = '{0, 0, 1, 0, 1, 1, 32'hDEAD0004, 6'b000000, 1, 32'hDEAD0004};
    vecs[14] = '{0, 1, 0, 0, 0, 1, 32'hCAFEF00D, 6'b000111, 0, 32'h0};

    set_in(0, 0, 0, 0, 0, 0, 32'd0);
    @(posedge clk);
    #1;
    chk_out("reset", 6'd0, 1'b0, 32'd0);
    chk("reset.stall_cycles", bus.stall_cycles, 32'd0);
    chk("reset.flush_count", {16'd0, bus.flush_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Vector table, all applied from RUN.
    exp_sc = 0;
    exp_fc = 0;
    for (int i = 0; i < 15; i++) begin
      step($sformatf("vec%0d", i), vecs[i].f, vecs[i].d, vecs[i].e, vecs[i].m, vecs[i].x,
           vecs[i].r, vecs[i].epc, vecs[i].stall, vecs[i].flush, vecs[i].pc);
      if (vecs[i].stall != 0) exp_sc++;
      if (vecs[i].flush) exp_fc++;
    end
    chk("vec.stall_cycles", bus.stall_cycles, exp_sc);
    chk("vec.flush_count", {16'd0, bus.flush_count}, exp_fc);

    // EX busy for three cycles.
    do_reset();
    for (int i = 0; i < 3; i++) step("ex3", 0, 0, 1, 0, 0, 0, 0, 6'b001111, 0, 0);
    chk("ex3.stall_cycles", bus.stall_cycles, 32'd3);

    // ERET while MEM bus busy for 4 cycles; later exceptions in PEND/FLUSH are ignored.
    do_reset();
    step("eret.c1", 0, 0, 0, 1, 1, 1, 32'hBFC00100, 6'b011111, 0, 0);
    step("eret.c2", 0, 0, 0, 1, 0, 0, 32'h0,        6'b011111, 0, 0);
    step("eret.c3", 0, 0, 0, 1, 1, 0, 32'h0,        6'b011111, 0, 0);
    step("eret.c4", 0, 0, 0, 1, 0, 0, 32'h0,        6'b011111, 0, 0);
    step("eret.drain", 0, 0, 0, 0, 1, 1, 32'h1111,  6'b011111, 0, 0);
    step("eret.flush", 0, 0, 0, 0, 1, 1, 32'h2222,  6'b000000, 1, 32'hBFC00100);
    step("eret.run", 0, 0, 0, 0, 0, 0, 32'h0,       6'b000000, 0, 0);
    chk("eret.flush_count", {16'd0, bus.flush_count}, 32'd1);
    chk("eret.stall_cycles", bus.stall_cycles, 32'd5);

    // Reset while PEND discards the pending exception.
    do_reset();
    step("rstpend.enter", 1, 0, 0, 0, 1, 0, 32'h0, 6'b011111, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 32'd0);
    #2 chk_out("rstpend.inrst", 6'd0, 0, 0);
    @(posedge clk);
    #1;
    chk("rstpend.stall_cycles", bus.stall_cycles, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    step("rstpend.after1", 0, 0, 0, 0, 0, 0, 0, 6'd0, 0, 0);
    step("rstpend.after2", 0, 0, 0, 0, 0, 0, 0, 6'd0, 0, 0);
    chk("rstpend.flush_count", {16'd0, bus.flush_count}, 32'd0);

    // Randomized run against the reference model, with occasional resets.
    do_reset();
    m_pending      = 0;
    m_flush_due    = 0;
    m_target       = 32'd0;
    m_stall_cycles = 32'd0;
    m_flush_count  = 16'd0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 59) == 0);
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
             $urandom);
      model_eval();
      #2 chk_out($sformatf("rand%0d", i), e_stall, e_flush, e_pc);
      @(posedge clk);
      model_clock();
      #1;
      chk($sformatf("rand%0d.stall_cycles", i), bus.stall_cycles, m_stall_cycles);
      chk($sformatf("rand%0d.flush_count", i), {16'd0, bus.flush_count}, {16'd0, m_flush_count});
    end

    // flush_count saturation.
    do_reset();
    @(negedge clk);
    set_in(0, 0, 0, 0, 1, 0, 32'd0);
    repeat (65535) @(posedge clk);
    #1;
    chk("sat.reach", {16'd0, bus.flush_count}, 32'h0000FFFF);
    repeat (5) @(posedge clk);
    #1;
    chk("sat.hold", {16'd0, bus.flush_count}, 32'h0000FFFF);
    chk("sat.no_stall", bus.stall_cycles, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
